// File: rtl/hazard_forwarding_unit_v2_if.sv
// Bundle of ID-stage hazard/forwarding signals.
// The master modport is the pipeline side. It drives the stage destinations, the ID operands
// and the status inputs, and it receives the mux selects and the load/clear/hold controls.
// The slave modport is the hazard/forwarding unit.
// REG_AW sets the register-address width. CNT_W sets the stall_count width.
interface hazard_forwarding_unit_v2_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              EX_Register_File_Enable;
  logic              MEM_Register_File_Enable;
  logic              WB_Register_File_Enable;
  logic [REG_AW-1:0] EX_RD;
  logic [REG_AW-1:0] MEM_RD;
  logic [REG_AW-1:0] WB_RD;
  logic [REG_AW-1:0] operandA;
  logic [REG_AW-1:0] operandB;
  logic              use_A;
  logic              use_B;
  logic              EX_load_instr;
  logic              branch_taken;
  logic              mem_busy;
  logic              stat_clr;
  logic [1:0]        forwardMX1;
  logic [1:0]        forwardMX2;
  logic              nPC_LE;
  logic              PC_LE;
  logic              IF_ID_LE;
  logic              CU_S;
  logic              IF_ID_CLR;
  logic              pipe_hold;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output EX_Register_File_Enable, MEM_Register_File_Enable, WB_Register_File_Enable,
    output EX_RD, MEM_RD, WB_RD, operandA, operandB, use_A, use_B,
    output EX_load_instr, branch_taken, mem_busy, stat_clr,
    input  forwardMX1, forwardMX2, nPC_LE, PC_LE, IF_ID_LE, CU_S, IF_ID_CLR, pipe_hold,
    input  stall_count
  );

  modport slave (
    input  EX_Register_File_Enable, MEM_Register_File_Enable, WB_Register_File_Enable,
    input  EX_RD, MEM_RD, WB_RD, operandA, operandB, use_A, use_B,
    input  EX_load_instr, branch_taken, mem_busy, stat_clr,
    output forwardMX1, forwardMX2, nPC_LE, PC_LE, IF_ID_LE, CU_S, IF_ID_CLR, pipe_hold,
    output stall_count
  );
endinterface

// File: rtl/hazard_forwarding_unit_v2.sv
// ID-stage hazard detection and operand forwarding for a 5-stage MIPS pipeline.
// Ports:
//   clk     - clock; all state updates on the rising edge.
//   reset_n - synchronous active-low reset.
//   hfu     - slave side of hazard_forwarding_unit_v2_if, carrying:
//             - inputs: EX/MEM/WB write enables and destinations, ID operands with their
//               use qualifiers, EX load flag, branch_taken, mem_busy and stat_clr;
//             - outputs: forwardMX1/2 (00 RF, 01 EX, 10 MEM, 11 WB), PC/nPC/IF_ID load
//               enables, CU_S (bubble inject), IF_ID_CLR, pipe_hold and stall_count.
// Each load-use hazard inserts LOAD_LATENCY bubbles. mem_busy freezes the whole pipeline.
module hazard_forwarding_unit_v2 #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned CNT_W        = 16
) (
  input logic                        clk,
  input logic                        reset_n,
  hazard_forwarding_unit_v2_if.slave hfu
);

  localparam int unsigned CntW = $clog2(LOAD_LATENCY) + 1;

  typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q;
  logic             hz;
  logic             stall;
  logic [1:0]       fwd_a, fwd_b;

  // EX is skipped when it holds a load: the data does not exist yet and the stall covers it.
  function automatic logic [1:0] fwd_sel(input logic              use_op,
                                         input logic [REG_AW-1:0] op,
                                         input logic              ex_en,
                                         input logic [REG_AW-1:0] ex_rd,
                                         input logic              ex_load,
                                         input logic              mem_en,
                                         input logic [REG_AW-1:0] mem_rd,
                                         input logic              wb_en,
                                         input logic [REG_AW-1:0] wb_rd);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_op && op != '0) begin
      if (ex_en && ex_rd == op && !ex_load) begin
        sel = 2'b01;
      end else if (mem_en && mem_rd == op) begin
        sel = 2'b10;
      end else if (wb_en && wb_rd == op) begin
        sel = 2'b11;
      end
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(hfu.use_A, hfu.operandA, hfu.EX_Register_File_Enable, hfu.EX_RD,
                    hfu.EX_load_instr, hfu.MEM_Register_File_Enable, hfu.MEM_RD,
                    hfu.WB_Register_File_Enable, hfu.WB_RD);
    fwd_b = fwd_sel(hfu.use_B, hfu.operandB, hfu.EX_Register_File_Enable, hfu.EX_RD,
                    hfu.EX_load_instr, hfu.MEM_Register_File_Enable, hfu.MEM_RD,
                    hfu.WB_Register_File_Enable, hfu.WB_RD);
  end

  assign hz = hfu.EX_load_instr && hfu.EX_Register_File_Enable && (hfu.EX_RD != '0) &&
              ((hfu.use_A && hfu.operandA == hfu.EX_RD) ||
               (hfu.use_B && hfu.operandB == hfu.EX_RD));

  // A bubble is only issued when memory is ready. Under mem_busy the freeze wins.
  assign stall = !hfu.mem_busy && (((state_q == StIdle) && hz) || (state_q == StLoadWait));

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  // The first bubble is issued from StIdle. cnt then counts the remaining LOAD_LATENCY-1
  // bubbles, so the bubble total does not depend on the operands seen while waiting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!hfu.mem_busy) begin
      case (state_q)
        StIdle: begin
          if (hz && LOAD_LATENCY > 1) begin
            state_d = StLoadWait;
            cnt_d   = CntW'(LOAD_LATENCY - 1);
          end
        end
        StLoadWait: begin
          if (cnt_q == CntW'(1)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    hfu.forwardMX1 = fwd_a;
    hfu.forwardMX2 = fwd_b;
    hfu.nPC_LE     = 1'b1;
    hfu.PC_LE      = 1'b1;
    hfu.IF_ID_LE   = 1'b1;
    hfu.CU_S       = 1'b0;
    hfu.IF_ID_CLR  = 1'b0;
    hfu.pipe_hold  = 1'b0;
    if (!reset_n) begin
      hfu.forwardMX1 = 2'b00;
      hfu.forwardMX2 = 2'b00;
    end else if (hfu.mem_busy) begin
      hfu.nPC_LE    = 1'b0;
      hfu.PC_LE     = 1'b0;
      hfu.IF_ID_LE  = 1'b0;
      hfu.pipe_hold = 1'b1;
    end else if (stall) begin
      // branch_taken is ignored here because its operands are stale while stalled.
      hfu.nPC_LE   = 1'b0;
      hfu.PC_LE    = 1'b0;
      hfu.IF_ID_LE = 1'b0;
      hfu.CU_S     = 1'b1;
    end else if (hfu.branch_taken) begin
      hfu.IF_ID_CLR = 1'b1;
    end
  end

  // Saturating bubble counter. stat_clr beats a concurrent increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_count_q <= '0;
    end else if (hfu.stat_clr) begin
      stall_count_q <= '0;
    end else if (stall && stall_count_q != '1) begin
      stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign hfu.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forwarding_unit_v2.sv
module tb_hazard_forwarding_unit_v2;

  typedef struct packed {
    logic       ex_en, mem_en, wb_en;
    logic [4:0] ex_rd, mem_rd, wb_rd, opa, opb;
    logic       use_a, use_b, ex_load, br, busy, clr;
  } stim_t;

  typedef struct packed {
    logic [9:0]  ctl;
    logic [15:0] cnt;
  } exp_t;

  // Control field order: {nPC_LE, PC_LE, IF_ID_LE, CU_S, IF_ID_CLR, pipe_hold}
  localparam logic [5:0] RUN    = 6'b111000;
  localparam logic [5:0] STALL  = 6'b000100;
  localparam logic [5:0] BRANCH = 6'b111010;
  localparam logic [5:0] FREEZE = 6'b000001;

  logic  clk = 1'b0;
  logic  reset_n = 1'b0;
  stim_t s_l1, s_l3, s_c2;
  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    m_l1 = 0, m_l3 = 0, m_c2 = 0;

  always #5 clk = ~clk;

  hazard_forwarding_unit_v2_if #(.REG_AW(5), .CNT_W(16)) if_l1 ();
  hazard_forwarding_unit_v2_if #(.REG_AW(5), .CNT_W(16)) if_l3 ();
  hazard_forwarding_unit_v2_if #(.REG_AW(5), .CNT_W(2))  if_c2 ();

  hazard_forwarding_unit_v2 #(.REG_AW(5), .LOAD_LATENCY(1), .CNT_W(16)) u_l1 (
    .clk(clk), .reset_n(reset_n), .hfu(if_l1));
  hazard_forwarding_unit_v2 #(.REG_AW(5), .LOAD_LATENCY(3), .CNT_W(16)) u_l3 (
    .clk(clk), .reset_n(reset_n), .hfu(if_l3));
  hazard_forwarding_unit_v2 #(.REG_AW(5), .LOAD_LATENCY(1), .CNT_W(2)) u_c2 (
    .clk(clk), .reset_n(reset_n), .hfu(if_c2));

  assign if_l1.EX_Register_File_Enable = s_l1.ex_en;   assign if_l1.EX_RD = s_l1.ex_rd;
  assign if_l1.MEM_Register_File_Enable = s_l1.mem_en; assign if_l1.MEM_RD = s_l1.mem_rd;
  assign if_l1.WB_Register_File_Enable = s_l1.wb_en;   assign if_l1.WB_RD = s_l1.wb_rd;
  assign if_l1.operandA = s_l1.opa;     assign if_l1.operandB = s_l1.opb;
  assign if_l1.use_A = s_l1.use_a;      assign if_l1.use_B = s_l1.use_b;
  assign if_l1.EX_load_instr = s_l1.ex_load;  assign if_l1.branch_taken = s_l1.br;
  assign if_l1.mem_busy = s_l1.busy;    assign if_l1.stat_clr = s_l1.clr;

  assign if_l3.EX_Register_File_Enable = s_l3.ex_en;   assign if_l3.EX_RD = s_l3.ex_rd;
  assign if_l3.MEM_Register_File_Enable = s_l3.mem_en; assign if_l3.MEM_RD = s_l3.mem_rd;
  assign if_l3.WB_Register_File_Enable = s_l3.wb_en;   assign if_l3.WB_RD = s_l3.wb_rd;
  assign if_l3.operandA = s_l3.opa;     assign if_l3.operandB = s_l3.opb;
  assign if_l3.use_A = s_l3.use_a;      assign if_l3.use_B = s_l3.use_b;
  assign if_l3.EX_load_instr = s_l3.ex_load;  assign if_l3.branch_taken = s_l3.br;
  assign if_l3.mem_busy = s_l3.busy;    assign if_l3.stat_clr = s_l3.clr;

  assign if_c2.EX_Register_File_Enable = s_c2.ex_en;   assign if_c2.EX_RD = s_c2.ex_rd;
  assign if_c2.MEM_Register_File_Enable = s_c2.mem_en; assign if_c2.MEM_RD = s_c2.mem_rd;
  assign if_c2.WB_Register_File_Enable = s_c2.wb_en;   assign if_c2.WB_RD = s_c2.wb_rd;
  assign if_c2.operandA = s_c2.opa;     assign if_c2.operandB = s_c2.opb;
  assign if_c2.use_A = s_c2.use_a;      assign if_c2.use_B = s_c2.use_b;
  assign if_c2.EX_load_instr = s_c2.ex_load;  assign if_c2.branch_taken = s_c2.br;
  assign if_c2.mem_busy = s_c2.busy;    assign if_c2.stat_clr = s_c2.clr;

  logic [9:0]  obs_l1, obs_l3, obs_c2;
  logic [15:0] cnt_l1, cnt_l3, cnt_c2;
  assign obs_l1 = {if_l1.forwardMX1, if_l1.forwardMX2, if_l1.nPC_LE, if_l1.PC_LE,
                   if_l1.IF_ID_LE, if_l1.CU_S, if_l1.IF_ID_CLR, if_l1.pipe_hold};
  assign obs_l3 = {if_l3.forwardMX1, if_l3.forwardMX2, if_l3.nPC_LE, if_l3.PC_LE,
                   if_l3.IF_ID_LE, if_l3.CU_S, if_l3.IF_ID_CLR, if_l3.pipe_hold};
  assign obs_c2 = {if_c2.forwardMX1, if_c2.forwardMX2, if_c2.nPC_LE, if_c2.PC_LE,
                   if_c2.IF_ID_LE, if_c2.CU_S, if_c2.IF_ID_CLR, if_c2.pipe_hold};
  assign cnt_l1 = if_l1.stall_count;
  assign cnt_l3 = if_l3.stall_count;
  assign cnt_c2 = {14'd0, if_c2.stall_count};

  function automatic stim_t mk(input logic ex_en, input logic [4:0] ex_rd, input logic ex_load,
                               input logic mem_en, input logic [4:0] mem_rd,
                               input logic wb_en, input logic [4:0] wb_rd,
                               input logic [4:0] opa, input logic use_a,
                               input logic [4:0] opb, input logic use_b);
    stim_t s;
    s = '0;
    s.ex_en = ex_en;   s.ex_rd = ex_rd;   s.ex_load = ex_load;
    s.mem_en = mem_en; s.mem_rd = mem_rd; s.wb_en = wb_en; s.wb_rd = wb_rd;
    s.opa = opa; s.use_a = use_a; s.opb = opb; s.use_b = use_b;
    return s;
  endfunction

  task automatic test_reset();
    exp_t e;
    s_l1 = mk(1, 5, 0, 1, 5, 0, 0, 5, 1, 0, 0);
    s_l3 = mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 9, 1);
    s_c2 = '0;
    repeat (2) @(posedge clk);
    sb_q.push_back('{ctl: {4'b0000, RUN}, cnt: 16'd0});
    sb_q.push_back('{ctl: {4'b0000, RUN}, cnt: 16'd0});
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if (obs_l1 !== e.ctl || cnt_l1 !== e.cnt) begin
      errors++;
      $display("FAIL reset_l1: got ctl %b cnt %0d, want ctl %b cnt %0d", obs_l1, cnt_l1,
               e.ctl, e.cnt);
    end
    e = sb_q.pop_front();
    checks++;
    if (obs_l3 !== e.ctl || cnt_l3 !== e.cnt) begin
      errors++;
      $display("FAIL reset_l3: got ctl %b cnt %0d, want ctl %b cnt %0d", obs_l3, cnt_l3,
               e.ctl, e.cnt);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    s_l1 = '0; s_l3 = '0; s_c2 = '0;
    m_l1 = 0; m_l3 = 0; m_c2 = 0;
  endtask

  task automatic test_forward();
    stim_t      st[7];
    logic [3:0] fw[7];
    exp_t       e;
    st[0] = mk(1, 5, 0, 1, 5, 0, 0, 5, 1, 0, 0);    fw[0] = 4'b01_00; // EX beats MEM
    st[1] = mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1);    fw[1] = 4'b00_00; // r0 never forwarded
    st[2] = mk(0, 5, 0, 1, 5, 1, 5, 5, 1, 0, 0);    fw[2] = 4'b10_00; // MEM beats WB
    st[3] = mk(0, 0, 0, 0, 0, 1, 12, 0, 0, 12, 1);  fw[3] = 4'b00_11; // WB only
    st[4] = mk(1, 5, 0, 0, 0, 0, 0, 5, 0, 5, 1);    fw[4] = 4'b00_01; // use_A low
    st[5] = mk(0, 0, 0, 1, 3, 1, 3, 3, 1, 3, 1);    fw[5] = 4'b10_10;
    st[6] = mk(1, 31, 0, 1, 31, 1, 31, 30, 1, 29, 1); fw[6] = 4'b00_00;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      s_l1 = st[i];
      sb_q.push_back('{ctl: {fw[i], RUN}, cnt: 16'(m_l1)});
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs_l1 !== e.ctl || cnt_l1 !== e.cnt) begin
        errors++;
        $display("FAIL forward step %0d: got ctl %b cnt %0d, want ctl %b cnt %0d", i, obs_l1,
                 cnt_l1, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_load_use_l1();
    stim_t      st[5];
    logic [9:0] ex[5];
    exp_t       e;
    st[0] = mk(1, 8, 1, 1, 8, 0, 0, 0, 0, 8, 1); ex[0] = {4'b00_10, STALL};
    st[1] = '0;                                  ex[1] = {4'b00_00, RUN};
    st[2] = mk(1, 8, 1, 1, 8, 0, 0, 0, 0, 8, 0); ex[2] = {4'b00_00, RUN};
    st[3] = mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0); ex[3] = {4'b00_00, RUN}; // load to r0
    st[4] = '0;                                  ex[4] = {4'b00_00, RUN};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      s_l1 = st[i];
      sb_q.push_back('{ctl: ex[i], cnt: 16'(m_l1)});
      if (ex[i][2]) m_l1++;
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs_l1 !== e.ctl || cnt_l1 !== e.cnt) begin
        errors++;
        $display("FAIL load_use_l1 step %0d: got ctl %b cnt %0d, want ctl %b cnt %0d", i,
                 obs_l1, cnt_l1, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_multi_cycle();
    stim_t      st[7];
    logic [9:0] ex[7];
    exp_t       e;
    st[0] = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 8, 1); ex[0] = {4'b00_00, STALL};
    st[1] = mk(0, 0, 0, 1, 4, 0, 0, 4, 1, 0, 0); st[1].busy = 1'b1;
    ex[1] = {4'b10_00, FREEZE};
    st[2] = '0; st[2].busy = 1'b1;               ex[2] = {4'b00_00, FREEZE};
    st[3] = '0; st[3].br = 1'b1;                 ex[3] = {4'b00_00, STALL};
    st[4] = '0;                                  ex[4] = {4'b00_00, STALL};
    st[5] = '0;                                  ex[5] = {4'b00_00, RUN};
    st[6] = '0;                                  ex[6] = {4'b00_00, RUN};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      s_l3 = st[i];
      sb_q.push_back('{ctl: ex[i], cnt: 16'(m_l3)});
      if (ex[i][2]) m_l3++;
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs_l3 !== e.ctl || cnt_l3 !== e.cnt) begin
        errors++;
        $display("FAIL multi_cycle step %0d: got ctl %b cnt %0d, want ctl %b cnt %0d", i,
                 obs_l3, cnt_l3, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_branch();
    stim_t      st[5];
    logic [9:0] ex[5];
    exp_t       e;
    st[0] = '0; st[0].br = 1'b1;                 ex[0] = {4'b00_00, BRANCH};
    st[1] = '0;                                  ex[1] = {4'b00_00, RUN};
    st[2] = mk(1, 8, 1, 0, 0, 0, 0, 8, 1, 0, 0); st[2].br = 1'b1;
    ex[2] = {4'b00_00, STALL};
    st[3] = '0; st[3].br = 1'b1; st[3].busy = 1'b1; ex[3] = {4'b00_00, FREEZE};
    st[4] = '0;                                  ex[4] = {4'b00_00, RUN};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      s_l1 = st[i];
      sb_q.push_back('{ctl: ex[i], cnt: 16'(m_l1)});
      if (ex[i][2]) m_l1++;
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs_l1 !== e.ctl || cnt_l1 !== e.cnt) begin
        errors++;
        $display("FAIL branch step %0d: got ctl %b cnt %0d, want ctl %b cnt %0d", i, obs_l1,
                 cnt_l1, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_saturate();
    stim_t hit;
    stim_t st;
    exp_t  e;
    logic [9:0] ex;
    hit = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 8, 1);
    for (int i = 0; i < 9; i++) begin
      if (i < 5)       begin st = hit; ex = {4'b0000, STALL}; end
      else if (i == 6) begin st = hit; st.clr = 1'b1; ex = {4'b0000, STALL}; end
      else             begin st = '0;  ex = {4'b0000, RUN}; end
      @(posedge clk);
      #1;
      s_c2 = st;
      sb_q.push_back('{ctl: ex, cnt: 16'(m_c2)});
      if (st.clr) m_c2 = 0;
      else if (ex[2] && m_c2 != 3) m_c2++;
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs_c2 !== e.ctl || cnt_c2 !== e.cnt) begin
        errors++;
        $display("FAIL saturate step %0d: got ctl %b cnt %0d, want ctl %b cnt %0d", i, obs_c2,
                 cnt_c2, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    stim_t      st[5];
    logic [9:0] ex[5];
    exp_t       e;
    st[0] = mk(1, 8, 1, 0, 0, 0, 0, 8, 1, 0, 0); ex[0] = {4'b00_00, STALL};
    st[1] = '0;                                  ex[1] = {4'b00_00, STALL};
    // Inputs that would otherwise select EX/MEM, freeze and branch; reset masks them all.
    st[2] = mk(1, 6, 0, 1, 7, 0, 0, 6, 1, 7, 1); st[2].br = 1'b1; st[2].busy = 1'b1;
    ex[2] = {4'b00_00, RUN};
    st[3] = '0;                                  ex[3] = {4'b00_00, RUN};
    st[4] = '0;                                  ex[4] = {4'b00_00, RUN};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      reset_n = (i == 2) ? 1'b0 : 1'b1;
      s_l3 = st[i];
      sb_q.push_back('{ctl: ex[i], cnt: 16'(m_l3)});
      if (i == 2) begin
        m_l3 = 0; m_l1 = 0; m_c2 = 0;
      end else if (ex[i][2]) begin
        m_l3++;
      end
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs_l3 !== e.ctl || cnt_l3 !== e.cnt) begin
        errors++;
        $display("FAIL reset_mid_wait step %0d: got ctl %b cnt %0d, want ctl %b cnt %0d", i,
                 obs_l3, cnt_l3, e.ctl, e.cnt);
      end
    end
  endtask

  initial begin
    s_l1 = '0; s_l3 = '0; s_c2 = '0;
    test_reset();
    test_forward();
    test_load_use_l1();
    test_multi_cycle();
    test_branch();
    test_saturate();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_forwarding_unit_v2.md
Name: hazard_forwarding_unit_v2

Overview:
Parametrised successor to the ID-stage hazard/forwarding unit of the 5-stage MIPS pipeline.
- Keeps EX>MEM>WB operand forwarding for both ID source muxes.
- Adds multi-cycle load-use stalls via a small FSM, r0 forwarding suppression, per-operand use qualifiers, taken-branch IF/ID flush, and a data-memory-busy global freeze.
- Adds a saturating stall-cycle performance counter.

Parameters:
REG_AW, 5, register-address width
LOAD_LATENCY, 1, bubbles inserted per load-use hazard (>=1)
CNT_W, 16, stall_count width

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  synchronous active-low reset
EX_Register_File_Enable  input  1  EX instr writes RF
MEM_Register_File_Enable  input  1  MEM instr writes RF
WB_Register_File_Enable  input  1  WB instr writes RF
EX_RD  input  REG_AW  EX destination
MEM_RD  input  REG_AW  MEM destination
WB_RD  input  REG_AW  WB destination
operandA  input  REG_AW  ID source A
operandB  input  REG_AW  ID source B
use_A  input  1  ID instr reads operandA
use_B  input  1  ID instr reads operandB
EX_load_instr  input  1  EX instr is a load
branch_taken  input  1  ID resolved taken branch/jump
mem_busy  input  1  data memory not ready; freeze pipeline
stat_clr  input  1  clear stall_count
forwardMX1  output  2  00 RF, 01 EX, 10 MEM, 11 WB for A
forwardMX2  output  2  same encoding for B
nPC_LE  output  1  nPC load enable
PC_LE  output  1  PC load enable
IF_ID_LE  output  1  IF/ID load enable
CU_S  output  1  1 = inject NOP control into ID/EX
IF_ID_CLR  output  1  1 = clear IF/ID to NOP next edge
pipe_hold  output  1  1 = hold ID/EX, EX/MEM, MEM/WB
stall_count  output  CNT_W  load-use bubble cycles, saturating

Behaviour:
- Forwarding is combinational.
  - A: if !use_A or operandA==0 -> 00.
  - Else EX (enable && EX_RD==operandA && !EX_load_instr) -> 01; else MEM match -> 10; else WB match -> 11; else 00.
  - B: identical, using use_B/operandB.
  - EX-load matches never select 01; they are covered by the stall.
- hz = EX_load_instr && EX_Register_File_Enable && EX_RD!=0 && ((use_A && operandA==EX_RD) || (use_B && operandB==EX_RD)).
- FSM states: IDLE, LOAD_WAIT; counter cnt is width clog2(LOAD_LATENCY)+1.
  - IDLE, hz, !mem_busy: stall this cycle. If LOAD_LATENCY>1, go to LOAD_WAIT with cnt=LOAD_LATENCY-1; else stay IDLE.
  - LOAD_WAIT: stall every cycle. When cnt==1, go to IDLE; else cnt-- (only when !mem_busy).
  - Total bubbles per hazard = LOAD_LATENCY, independent of operand changes during the wait.
- Priority per cycle:
  1. mem_busy=1: PC_LE=nPC_LE=IF_ID_LE=0, CU_S=0, IF_ID_CLR=0, pipe_hold=1. FSM and counters frozen; no bubble is counted.
  2. Else stall (IDLE&&hz, or LOAD_WAIT): PC_LE=nPC_LE=IF_ID_LE=0, CU_S=1, IF_ID_CLR=0, pipe_hold=0. branch_taken is ignored, because the branch operands are stale.
  3. Else branch_taken: all LE=1, CU_S=0, IF_ID_CLR=1, pipe_hold=0.
  4. Else: all LE=1, CU_S=0, IF_ID_CLR=0, pipe_hold=0.
- stall_count increments by 1 on each edge where case 2 holds, saturating at all-ones. stat_clr has priority over increment and sets it to 0 on the next edge.
- Reset: on an edge with reset_n=0, state=IDLE, cnt=0, stall_count=0.
  - While reset_n=0, outputs are forced: forwardMX1=forwardMX2=00, all LE=1, CU_S=0, IF_ID_CLR=0, pipe_hold=0.
  - Reset mid-LOAD_WAIT aborts the remaining bubbles.

Test Plan:
- EX writes r5 (non-load), ID operandA=5, use_A=1; MEM also writes r5 -> forwardMX1=01 (EX wins); operandA=0 with EX_RD=0 enabled -> 00.
- LOAD_LATENCY=1: EX load to r8, operandB=8, use_B=1 -> exactly 1 cycle with PC_LE=0 and CU_S=1; stall_count 0->1. Same with use_B=0 -> no stall.
- LOAD_LATENCY=3: load-use hit -> 3 consecutive stall cycles, then IDLE; mem_busy high during 2nd bubble for 2 cycles -> pipe_hold=1 and CU_S=0 for those cycles, still 3 bubbles total, stall_count=3.
- branch_taken with no hazard -> IF_ID_CLR=1 for that cycle only; branch_taken coincident with load-use hit -> IF_ID_CLR=0, CU_S=1.
- CNT_W=2: 5 stall cycles -> stall_count saturates at 3; stat_clr pulse -> 0 next edge, with priority over a concurrent stall.
- reset_n low during LOAD_WAIT -> next cycle all LE=1, CU_S=0, stall_count=0, FSM IDLE; reset_n low with matching inputs -> forwardMX1=forwardMX2=00.
